// File: rtl/dg0045_pkg.sv
// Shared types and constants for the DG0045 CPU/debug-host RAM arbiter.
// Holds the arbiter FSM encoding, the phase slot numbers and the RAM geometry.
package dg0045_pkg;

    localparam int RAM_AW = 5;
    localparam int RAM_DW = 4;

    // Phase slots within the 8-clk machine cycle used by the host path.
    localparam logic [2:0] HOST_PH_ADDR  = 3'd0;
    localparam logic [2:0] HOST_PH_WR    = 3'd1;
    localparam logic [2:0] HOST_PH_ACK   = 3'd2;
    localparam logic [2:0] HOST_PH_LATCH = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOST = 2'd1,
        ST_ACK  = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic              we;
        logic [RAM_AW-1:0] addr;
        logic [RAM_DW-1:0] wdata;
    } host_cmd_t;

endpackage

// File: rtl/dg0045_phase_ctr.sv
// 3-bit machine-cycle phase counter; advances only on qualified clocks so it
// stays in lockstep with the core clock divider.
module dg0045_phase_ctr (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    output logic [2:0] phase
);

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking so every flop samples pre-edge values.
        if (!rst_n) begin
            phase <= 3'd0;
        end else if (ena) begin
            phase <= phase + 3'd1;
        end
    end

endmodule

// File: rtl/dg0045_ram_arbiter.sv
// Shares the 32x4 data RAM between the CPU and a debug host using phase slots 0-1.
// The host path exists only when DG0045_HOST_PORT_EN is defined; otherwise the CPU owns the RAM.
module dg0045_ram_arbiter
    import dg0045_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [RAM_AW-1:0] cpu_addr,
    input  logic [RAM_DW-1:0] cpu_wdata,
    input  logic              cpu_we,
    output logic [RAM_DW-1:0] cpu_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [RAM_AW-1:0] host_addr,
    input  logic [RAM_DW-1:0] host_wdata,
    output logic              host_ack,
    output logic [RAM_DW-1:0] host_rdata,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [RAM_DW-1:0] ram_din,
    output logic              ram_we,
    input  logic [RAM_DW-1:0] ram_dout,
    output logic              collision
);

    logic [2:0] phase;

    dg0045_phase_ctr u_phase_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .phase (phase)
    );

`ifdef DG0045_HOST_PORT_EN

    arb_state_e        state_q;
    arb_state_e        state_d;
    host_cmd_t         cmd_q;
    logic [RAM_DW-1:0] host_rdata_q;
    logic [RAM_DW-1:0] cpu_hold_q;
    logic              collision_q;
    logic              host_owns;
    logic              start_access;
    logic              finish_access;

    assign host_owns     = (state_q == ST_HOST);
    assign start_access  = (state_q == ST_IDLE) && (state_d == ST_HOST);
    assign finish_access = host_owns && (state_d == ST_ACK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cmd_q        <= '0;
            host_rdata_q <= '0;
            cpu_hold_q   <= '0;
            collision_q  <= 1'b0;
        end else if (ena) begin
            state_q <= state_d;
            if (start_access) begin
                cmd_q <= '{we: host_we, addr: host_addr, wdata: host_wdata};
            end
            if (finish_access && !cmd_q.we) begin
                host_rdata_q <= ram_dout;
            end
            // Track the CPU view while it owns the RAM so it can be replayed during HOST.
            if (!host_owns) begin
                cpu_hold_q <= ram_dout;
            end
            if (host_owns && cpu_we) begin
                collision_q <= 1'b1;
            end
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_d   = state_q;
        host_ack  = 1'b0;
        ram_addr  = cpu_addr;
        ram_din   = cpu_wdata;
        ram_we    = cpu_we;
        cpu_rdata = ram_dout;
        unique case (state_q)
            ST_IDLE: begin
                if (ena && (phase == HOST_PH_LATCH) && host_req) begin
                    state_d = ST_HOST;
                end
            end
            ST_HOST: begin
                // CPU strobe is blocked here; a frozen clock also suppresses the host strobe.
                ram_addr  = cmd_q.addr;
                ram_din   = cmd_q.wdata;
                ram_we    = ena && cmd_q.we && (phase == HOST_PH_WR);
                cpu_rdata = cpu_hold_q;
                if (ena) begin
                    if (phase == HOST_PH_WR) begin
                        state_d = ST_ACK;
                    end else if (phase != HOST_PH_ADDR) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_ACK: begin
                host_ack = ena && (phase == HOST_PH_ACK);
                if (ena) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign host_rdata = host_rdata_q;
    assign collision  = collision_q;

`else

    logic unused_host;

    assign unused_host = ^{phase, host_req, host_we, host_addr, host_wdata};
    assign ram_addr    = cpu_addr;
    assign ram_din     = cpu_wdata;
    assign ram_we      = cpu_we;
    assign cpu_rdata   = ram_dout;
    assign host_ack    = 1'b0;
    assign host_rdata  = '0;
    assign collision   = 1'b0;

`endif

endmodule

// File: tb/tb_dg0045_ram_arbiter.sv
// Self-checking bench for dg0045_ram_arbiter with a behavioural 32x4 RAM and a result scoreboard.
// Exercises the host path when DG0045_HOST_PORT_EN is defined, the CPU-only build otherwise.
module tb_dg0045_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic [4:0] cpu_addr = '0;
    logic [3:0] cpu_wdata = '0;
    logic       cpu_we = 1'b0;
    logic [3:0] cpu_rdata;
    logic       host_req = 1'b0;
    logic       host_we = 1'b0;
    logic [4:0] host_addr = '0;
    logic [3:0] host_wdata = '0;
    logic       host_ack;
    logic [3:0] host_rdata;
    logic [4:0] ram_addr;
    logic [3:0] ram_din;
    logic       ram_we;
    logic [3:0] ram_dout;
    logic       collision;

    int         n_pass = 0;
    int         n_total = 0;
    int         n_fail = 0;
    logic [3:0] shadow [32];
    logic [3:0] sb_q [$];
    logic [3:0] last_rd = '0;

    dg0045_ram_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_we     (cpu_we),
        .cpu_rdata  (cpu_rdata),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_ack   (host_ack),
        .host_rdata (host_rdata),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_we     (ram_we),
        .ram_dout   (ram_dout),
        .collision  (collision)
    );

    always #5 clk = ~clk;

    // External RAM: synchronous write on ram_we, combinational read.
    logic [3:0] mem [32];
    logic       mem_init = 1'b1;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 32; i++) mem[i] <= 4'(i) ^ 4'h5;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_din;
        end
    end

    assign ram_dout = mem[ram_addr];

    // Reference phase: advances once per qualified clock, wraps 7 -> 0.
    logic [2:0] exp_phase;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) exp_phase <= 3'd0;
        else if (ena) exp_phase <= exp_phase + 3'd1;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_total++;
        assert (observed === expected) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (failure #%0d)", tag, observed, expected, n_fail);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic wait_phase(input logic [2:0] p);
        for (int i = 0; i < 9 && exp_phase != p; i++) cyc();
        if (exp_phase != p) check("wait_phase_timeout", 32'(exp_phase), 32'(p));
    endtask

    task automatic cpu_read(input logic [4:0] addr, input string tag);
        cpu_addr = addr;
        sb_q.push_back(shadow[addr]);
        smp();
        check(tag, 32'(cpu_rdata), 32'(sb_q.pop_front()));
    endtask

    task automatic cpu_write(input logic [4:0] addr, input logic [3:0] data);
        cpu_addr  = addr;
        cpu_wdata = data;
        cpu_we    = 1'b1;
        cyc();
        cpu_we    = 1'b0;
        shadow[addr] = data;
    endtask

`ifdef DG0045_HOST_PORT_EN
    // One host access issued in phase start_ph; optional ena gap in phase 1 and CPU collision.
    task automatic host_txn(input logic we, input logic [4:0] addr, input logic [3:0] wdata,
                            input logic [2:0] start_ph, input int gap, input logic collide,
                            input string tag);
        int         lat;
        int         n_we;
        int         off;
        logic       acked;
        logic       we_ok;
        logic [3:0] hold_exp;
        hold_exp = shadow[cpu_addr];
        wait_phase(start_ph);
        off        = 7 - int'(start_ph);
        host_req   = 1'b1;
        host_we    = we;
        host_addr  = addr;
        host_wdata = wdata;
        if (we) begin
            sb_q.push_back(last_rd);
            shadow[addr] = wdata;
        end else begin
            sb_q.push_back(shadow[addr]);
            last_rd = shadow[addr];
        end
        lat = 0; n_we = 0; acked = 1'b0; we_ok = 1'b1;
        for (int k = 1; k <= 24 && !acked; k++) begin
            cyc();
            if (k == off + 1) begin
                host_req   = 1'b0;
                host_we    = ~we;
                host_addr  = ~addr;
                host_wdata = ~wdata;
            end
            if (gap > 0 && k == off + 2) ena = 1'b0;
            if (k == off + 2 + gap) ena = 1'b1;
            if (collide && k == off + 2) begin
                cpu_we    = 1'b1;
                cpu_wdata = ~shadow[cpu_addr];
            end
            if (collide && k == off + 3) cpu_we = 1'b0;
            smp();
            if (k == off + 1) check({tag, "_cpu_hold"}, 32'(cpu_rdata), 32'(hold_exp));
            if (ram_we) begin
                n_we++;
                if (ram_addr !== addr || ram_din !== wdata) we_ok = 1'b0;
            end
            if (host_ack) begin
                acked = 1'b1;
                lat   = k;
                check({tag, "_rdata"}, 32'(host_rdata), 32'(sb_q.pop_front()));
            end
        end
        check({tag, "_ack_latency"}, lat, off + 3 + gap);
        check({tag, "_we_count"}, n_we, we ? 1 : 0);
        check({tag, "_we_addr_data"}, 32'(we_ok), 1);
        cyc();
        smp();
        check({tag, "_ack_one_clk"}, 32'(host_ack), 0);
    endtask
`endif

    initial begin
        int n_ack;
        int n_we;
        for (int i = 0; i < 32; i++) shadow[i] = 4'(i) ^ 4'h5;
        ena = 1'b1;
        repeat (2) cyc();
        mem_init = 1'b0;
        smp();
        check("rst_host_ack", 32'(host_ack), 0);
        check("rst_host_rdata", 32'(host_rdata), 0);
        check("rst_collision", 32'(collision), 0);
        check("rst_ram_we", 32'(ram_we), 0);
        check("rst_cpu_rdata", 32'(cpu_rdata), 32'(shadow[0]));
        cyc();
        rst_n = 1'b1;

        cpu_read(5'h07, "cpu_rd_07");
        cpu_write(5'h04, 4'hC);
        cpu_read(5'h04, "cpu_rd_04");
        cpu_addr  = 5'h09;
        cpu_wdata = 4'h3;
        cpu_we    = 1'b1;
        smp();
        check("pass_ram_we", 32'(ram_we), 1);
        check("pass_ram_addr", 32'(ram_addr), 32'h09);
        check("pass_ram_din", 32'(ram_din), 32'h3);
        cyc();
        cpu_we = 1'b0;
        shadow[9] = 4'h3;
        cpu_read(5'h09, "cpu_rd_09");

`ifdef DG0045_HOST_PORT_EN
        cpu_addr = 5'h07;
        host_txn(1'b1, 5'h13, 4'hA, 3'd7, 0, 1'b0, "hwr_13");
        host_txn(1'b0, 5'h13, 4'h0, 3'd7, 0, 1'b0, "hrd_13");
        cpu_read(5'h13, "cpu_rd_13");

        cpu_addr = 5'h02;
        host_txn(1'b0, 5'h05, 4'h0, 3'd7, 0, 1'b1, "coll");
        check("collision_set", 32'(collision), 1);
        cpu_read(5'h02, "cpu_rd_02_blocked");

        // A request seen only in phase 3 never reaches a phase-7 latch.
        wait_phase(3'd3);
        host_req  = 1'b1;
        host_we   = 1'b1;
        host_addr = 5'h06;
        cyc();
        host_req = 1'b0;
        n_ack = 0; n_we = 0;
        for (int k = 0; k < 12; k++) begin
            smp();
            if (host_ack) n_ack++;
            if (ram_we) n_we++;
            cyc();
        end
        check("pulse_no_ack", n_ack, 0);
        check("pulse_no_we", n_we, 0);

        cpu_addr = 5'h07;
        host_txn(1'b0, 5'h04, 4'h0, 3'd3, 0, 1'b0, "hrd_ph3");
        cpu_addr = 5'h04;
        host_txn(1'b1, 5'h0A, 4'h6, 3'd7, 5, 1'b0, "hwr_gap");
        host_txn(1'b0, 5'h0A, 4'h0, 3'd7, 0, 1'b0, "hrd_gap");
        check("collision_sticky", 32'(collision), 1);

        // Reset in the middle of a host write.
        wait_phase(3'd7);
        host_req   = 1'b1;
        host_we    = 1'b1;
        host_addr  = 5'h0B;
        host_wdata = 4'h9;
        cyc();
        host_req = 1'b0;
        cyc();
        smp();
        check("rst_mid_pre_we", 32'(ram_we), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_we_drop", 32'(ram_we), 0);
        check("rst_mid_no_ack", 32'(host_ack), 0);
        cyc();
        smp();
        check("rst_mid_collision", 32'(collision), 0);
        check("rst_mid_rdata", 32'(host_rdata), 0);
        cyc();
        rst_n   = 1'b1;
        last_rd = 4'h0;
        n_ack = 0;
        for (int k = 0; k < 12; k++) begin
            smp();
            if (host_ack) n_ack++;
            cyc();
        end
        check("rst_mid_abandon", n_ack, 0);
        cpu_read(5'h0B, "cpu_rd_0b_unwritten");
        check("scoreboard_empty", sb_q.size(), 0);
`else
        // CPU-only build: host pins are inert and the CPU always owns the RAM.
        n_ack = 0; n_we = 0;
        cpu_addr  = 5'h1F;
        cpu_wdata = 4'hD;
        for (int k = 0; k < 48; k++) begin
            host_req   = 1'($urandom_range(0, 1));
            host_we    = 1'($urandom_range(0, 1));
            host_addr  = 5'($urandom);
            host_wdata = 4'($urandom);
            cpu_we     = host_req;
            if (host_req) shadow[5'h1F] = 4'hD;
            smp();
            if (host_ack !== 1'b0 || host_rdata !== 4'h0 || collision !== 1'b0) n_ack++;
            if (ram_we !== cpu_we || ram_addr !== cpu_addr) n_we++;
            cyc();
        end
        host_req = 1'b0;
        cpu_we   = 1'b0;
        check("off_host_inert", n_ack, 0);
        check("off_cpu_owns", n_we, 0);
        cpu_read(5'h1F, "off_cpu_rd_1f");
        cpu_read(5'h13, "off_cpu_rd_13");
        check("scoreboard_empty", sb_q.size(), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
